// File: rtl/bram_fifo_pkg.sv
// Shared sizing constants for the BRAM-backed stream FIFO.
// Latency: n/a (constants only).
// Backpressure: n/a.
package bram_fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 10;
  localparam int DEPTH          = 2 ** DEF_ADDR_WIDTH;
  localparam int OB_DEPTH       = 2;

endpackage

// File: rtl/bram_fifo_out_stage.sv
// Two-entry head/tail skid buffer that turns the RAM's registered read into first-word-fall-through.
// Latency: a load is visible at out_data the cycle after it is presented when the buffer is empty.
// Backpressure: caller must only load when a slot is (or is being made) free; head holds while not popped.
module bram_fifo_out_stage
  import bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  pop,
  output logic [1:0]            ob_occ,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam logic [1:0] OB_FULL = 2'(OB_DEPTH);

  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;

  // head is never cleared on the last pop so out_data keeps its last value when empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head   <= '0;
      tail   <= '0;
      ob_occ <= '0;
    end else begin
      case ({load, pop})
        2'b10: begin
          if (ob_occ == 2'd0) head <= load_data;
          else                tail <= load_data;
          ob_occ <= ob_occ + 2'd1;
        end
        2'b01: begin
          if (ob_occ == OB_FULL) head <= tail;
          ob_occ <= ob_occ - 2'd1;
        end
        2'b11: begin
          if (ob_occ == OB_FULL) begin
            head <= tail;
            tail <= load_data;
          end else begin
            head <= load_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (ob_occ != 2'd0);
  assign out_data  = head;

endmodule

// File: rtl/dual_port_ram.sv
// Two-port synchronous RAM, read-before-write on each port, no reset on contents.
// Latency: out1/out2 valid one clock after the address is presented.
// Backpressure: none; every cycle is a read (and optional write) on both ports.
module dual_port_ram #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [ADDR_WIDTH-1:0] addr2,
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic [DATA_WIDTH-1:0] data2,
  input  logic                  we1,
  input  logic                  we2,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [DATA_WIDTH-1:0] out2
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we1) mem[addr1] <= data1;
    if (we2) mem[addr2] <= data2;
    out1 <= mem[addr1];
    out2 <= mem[addr2];
  end

endmodule

// File: rtl/bram_stream_fifo.sv
// Valid/ready stream FIFO on a dual_port_ram, FWFT output; capacity 2**ADDR_WIDTH+2; BRAM_FIFO_LEVEL_EN adds level.
// Latency: push at edge k on empty FIFO -> RAM read at k+1 -> out_valid after edge k+2.
// Backpressure: in_ready drops when the RAM holds DEPTH words; reads stall while the output buffer is committed.
module bram_stream_fifo
  import bram_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef BRAM_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH+1:0] level
`endif
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         ram_count;
  logic                  rd_pending;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  rd_issue;
  logic [2:0]            ob_after;
  logic [1:0]            ob_occ;
  logic [DATA_WIDTH-1:0] ram_out2;
  logic [DATA_WIDTH-1:0] ram_out1_unused;

  assign ram_count = wr_ptr - rd_ptr;
  assign full      = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign in_ready  = reset & ~full;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Only fetch when the word is guaranteed a buffer slot on arrival
  assign ob_after  = {1'b0, ob_occ} + {2'b00, rd_pending} - {2'b00, pop};
  assign rd_issue  = (ram_count != '0) && (ob_after < 3'(OB_DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_pending <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + PW'(1);
      if (rd_issue) rd_ptr <= rd_ptr + PW'(1);
      rd_pending <= rd_issue;
    end
  end

  dual_port_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .addr1 (wr_ptr[ADDR_WIDTH-1:0]),
    .addr2 (rd_ptr[ADDR_WIDTH-1:0]),
    .data1 (in_data),
    .data2 ('0),
    .we1   (push),
    .we2   (1'b0),
    .out1  (ram_out1_unused),
    .out2  (ram_out2)
  );

  bram_fifo_out_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_stage (
    .clk       (clk),
    .reset     (reset),
    .load      (rd_pending),
    .load_data (ram_out2),
    .pop       (pop),
    .ob_occ    (ob_occ),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

`ifdef BRAM_FIFO_LEVEL_EN
  assign level = {1'b0, ram_count} + (ADDR_WIDTH+2)'(rd_pending) + (ADDR_WIDTH+2)'(ob_occ);
`endif

endmodule

// File: tb/tb_bram_stream_fifo.sv
// Directed bench for bram_stream_fifo: reset, latency, fill, streaming, backpressure, mid-op reset.
module tb_bram_stream_fifo;

  localparam int AW  = 5;
  localparam int DW  = 10;
  localparam int CAP = 34;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
`ifdef BRAM_FIFO_LEVEL_EN
  logic [AW+1:0] level;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bram_stream_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef BRAM_FIFO_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  task automatic test_reset();
    #1;
    reset = 1'b0; in_valid = 1'b1; in_data = 10'h3ff; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 10'h000) begin errors++; $display("FAIL reset_out_data got=%h exp=000", out_data); end
`ifdef BRAM_FIFO_LEVEL_EN
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
`endif
    in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_single_word();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 10'h2a5;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_k got=%b exp=0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_k1 got=%b exp=0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_k2_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 10'h2a5) begin errors++; $display("FAIL single_k2_data got=%h exp=2a5", out_data); end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 10'h2a5) begin
        errors++; $display("FAIL single_hold got=%b/%h exp=1/2a5", out_valid, out_data);
      end
    end
`ifdef BRAM_FIFO_LEVEL_EN
    checks++; if (level !== 7'd1) begin errors++; $display("FAIL single_level got=%0d exp=1", level); end
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_popped got=%b exp=0", out_valid); end
    checks++; if (out_data !== 10'h2a5) begin errors++; $display("FAIL single_empty_hold got=%h exp=2a5", out_data); end
  endtask

  task automatic test_fill();
    int acc = 0;
    int idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (in_ready) begin
        in_valid = 1'b1; in_data = DW'(acc); acc++;
      end else begin
        in_valid = 1'b0;
        break;
      end
    end
    in_valid = 1'b0;
    checks++; if (acc != CAP) begin errors++; $display("FAIL fill_accepted got=%0d exp=%0d", acc, CAP); end
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
`ifdef BRAM_FIFO_LEVEL_EN
    checks++; if (level !== 7'd34) begin errors++; $display("FAIL fill_level got=%0d exp=34", level); end
`endif
    for (int c = 0; c < 100 && idx < CAP; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (out_valid) begin
        checks++;
        if (out_data !== DW'(idx)) begin errors++; $display("FAIL fill_order got=%h exp=%h", out_data, DW'(idx)); end
        idx++;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (idx != CAP) begin errors++; $display("FAIL fill_drained got=%0d exp=%0d", idx, CAP); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_empty got=%b exp=0", out_valid); end
`ifdef BRAM_FIFO_LEVEL_EN
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL fill_level_end got=%0d exp=0", level); end
`endif
  endtask

  task automatic test_streaming();
    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp;
    int sent = 0;
    int got = 0;
    int gaps = 0;
    bit primed = 1'b0;
    for (int c = 0; c < 230; c++) begin
      @(negedge clk);
      in_valid  = (c < 200);
      in_data   = DW'(sent + 10'h040);
      out_ready = 1'b1;
      if (out_valid) begin
        primed = 1'b1;
        checks++;
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        if (out_data !== exp) begin errors++; $display("FAIL stream_data got=%h exp=%h", out_data, exp); end
        got++;
      end else if (primed && got < 200) begin
        gaps++;
      end
      if (in_valid && in_ready) begin sb.push_back(in_data); sent++; end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (sent != 200) begin errors++; $display("FAIL stream_sent got=%0d exp=200", sent); end
    checks++; if (got != 200) begin errors++; $display("FAIL stream_got got=%0d exp=200", got); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps got=%0d exp=0", gaps); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp;
    logic [DW-1:0] prev_data = '0;
    bit prev_stall = 1'b0;
    int sent = 0;
    int got = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++; $display("FAIL bp_stall_hold got=%b/%h exp=1/%h", out_valid, out_data, prev_data);
        end
      end
      in_valid  = (c < 400) && ($urandom_range(0, 1) == 1);
      in_data   = DW'($urandom_range(0, 1023));
      out_ready = (c >= 400) || ($urandom_range(0, 1) == 1);
      if (out_valid && out_ready) begin
        checks++;
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        if (out_data !== exp) begin errors++; $display("FAIL bp_data got=%h exp=%h", out_data, exp); end
        got++;
      end
      if (in_valid && in_ready) begin sb.push_back(in_data); sent++; end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (got != sent) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", got, sent); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_mid_reset();
    bit seen = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = DW'(10'h100 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 10'h100) begin
      errors++; $display("FAIL midrst_queued got=%b/%h exp=1/100", out_valid, out_data);
    end
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
`ifdef BRAM_FIFO_LEVEL_EN
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL midrst_level got=%0d exp=0", level); end
`endif
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1; in_data = 10'h155;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL midrst_timeout got=0 exp=1"); end
    checks++; if (out_data !== 10'h155) begin errors++; $display("FAIL midrst_first got=%h exp=155", out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill();
    test_streaming();
    test_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
